// File: rtl/wb_master_if.sv
// Wishbone master bridge for one pipeline memory port, with bus error, watchdog and flush draining.
// Optional read-reuse buffer enabled by defining WB_MASTER_RDBUF_REUSE_EN.
module wb_master_if #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SW        = DW / 8,
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [DW-1:0]      cpu_data_i,
  input  logic [SW-1:0]      cpu_sel_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               stallreq,
  output logic               bus_err_o,
  input  logic [DW-1:0]      wishbone_data_i,
  input  logic               wishbone_ack_i,
  input  logic               wishbone_err_i,
  output logic [AW-1:0]      wishbone_addr_o,
  output logic [DW-1:0]      wishbone_data_o,
  output logic               wishbone_we_o,
  output logic [SW-1:0]      wishbone_sel_o,
  output logic               wishbone_stb_o,
  output logic               wishbone_cyc_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam int CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST = TO_LAST_I[CW-1:0];

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            cyc_q, cyc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rd_buf_q, rd_buf_d;
  logic            err_q, err_d;

  logic active, to_hit, done, err_done, accept, hit, rd_ack;

  assign active   = (state_q == S_BUSY) || (state_q == S_DRAIN);
  assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign done     = active && (wishbone_ack_i || wishbone_err_i || to_hit);
  // Ack wins over a simultaneous err, so an error completion requires !ack.
  assign err_done = done && !wishbone_ack_i;
  assign rd_ack   = (state_q == S_BUSY) && wishbone_ack_i && !we_q;
  assign accept   = (state_q == S_IDLE) && cpu_ce_i && !flush_i && !hit;

`ifdef WB_MASTER_RDBUF_REUSE_EN
  logic [AW-1:0] tag_addr_q;
  logic [SW-1:0] tag_sel_q;
  logic          tag_vld_q;

  // Uncached kseg1 reads always go to the bus.
  assign hit = (state_q == S_IDLE) && cpu_ce_i && !cpu_we_i && !flush_i && tag_vld_q &&
               (cpu_addr_i == tag_addr_q) && (cpu_sel_i == tag_sel_q) &&
               (cpu_addr_i[AW-1:AW-3] != 3'b101);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_addr_q <= '0;
      tag_sel_q  <= '0;
      tag_vld_q  <= 1'b0;
    end else if (accept && cpu_we_i) begin
      tag_vld_q <= 1'b0;
    end else if (rd_ack) begin
      tag_addr_q <= addr_q;
      tag_sel_q  <= sel_q;
      tag_vld_q  <= 1'b1;
    end else if (err_done) begin
      tag_vld_q <= 1'b0;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cyc_q    <= 1'b0;
      cnt_q    <= '0;
      rd_buf_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      rd_buf_q <= rd_buf_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    cnt_d      = cnt_q;
    rd_buf_d   = rd_buf_q;
    err_d      = 1'b0;
    stallreq   = 1'b0;
    cpu_data_o = '0;

    if (active && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          cpu_data_o = rd_buf_q;
        end else if (accept) begin
          stallreq = 1'b1;
          addr_d   = cpu_addr_i;
          wdata_d  = cpu_data_i;
          we_d     = cpu_we_i;
          sel_d    = cpu_sel_i;
          cyc_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq = !done;
        if (done) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          err_d      = err_done;
          rd_buf_d   = rd_ack ? wishbone_data_i : '0;
          cpu_data_o = rd_ack ? wishbone_data_i : '0;
          if (flush_i)                 state_d = S_IDLE;
          else if (stall_i[STALL_IDX]) state_d = S_HOLD;
          else                         state_d = S_IDLE;
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      // The bus cycle runs to completion; any returned data is dropped.
      S_DRAIN: begin
        stallreq = cpu_ce_i;
        if (done) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          err_d   = err_done;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        cpu_data_o = rd_buf_q;
        if (!stall_i[STALL_IDX] || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdata_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = cyc_q;
  assign wishbone_cyc_o  = cyc_q;
  assign bus_err_o       = err_q;
  assign state_o         = state_q;

endmodule
